// File: rtl/prg_fetch_if.sv
// prg_fetch_if: handshake/bus bundle between the program loader / control unit
// (master) and the program-fetch unit (slave).
//   ld_en/ld_addr/ld_data : instruction-store write port
//   start                 : begin execution at address 0
//   br_en/br_target       : fetch redirect
//   ready                 : consumer accepts the presented instruction
//   pc/instr/op/valid     : presented instruction
//   busy/halted           : controller status
interface prg_fetch_if #(
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 8,
    parameter int OP_W    = 4
);
    localparam int AW = $clog2(DEPTH);

    logic               ld_en;
    logic [AW-1:0]      ld_addr;
    logic [INSTR_W-1:0] ld_data;
    logic               start;
    logic               br_en;
    logic [AW-1:0]      br_target;
    logic               ready;
    logic [AW-1:0]      pc;
    logic [INSTR_W-1:0] instr;
    logic [OP_W-1:0]    op;
    logic               valid;
    logic               busy;
    logic               halted;

    modport master (
        output ld_en, ld_addr, ld_data, start, br_en, br_target, ready,
        input  pc, instr, op, valid, busy, halted
    );

    modport slave (
        input  ld_en, ld_addr, ld_data, start, br_en, br_target, ready,
        output pc, instr, op, valid, busy, halted
    );
endinterface

// File: rtl/prg_fetch.sv
// prg_fetch: writable DEPTH-entry instruction store, wrapping fetch pointer and
// a registered output stage with valid/ready toward the control unit.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : prg_fetch_if slave (load port, start, branch, ready in;
//          pc/instr/op/valid/busy/halted out)
// Controller: IDLE -> (start) -> RUN -> (HALT_OP accepted) -> HALTED -> (start) -> RUN.
module prg_fetch #(
    parameter int              INSTR_W = 16,
    parameter int              DEPTH   = 8,
    parameter int              OP_W    = 4,
    parameter logic [OP_W-1:0] HALT_OP = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    prg_fetch_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED
    } state_e;

    state_e             state_q, state_d;
    logic [AW-1:0]      fpc_q, fpc_d;
    logic [AW-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               halted_q, halted_d;

    logic [INSTR_W-1:0] store_q [DEPTH];
    logic [OP_W-1:0]    op;
    logic               halt_presented;

    assign op             = instr_q[INSTR_W-1 -: OP_W];
    assign halt_presented = valid_q && (op == HALT_OP);

    // Store is not reset. Loading is locked out while running so the program
    // cannot change under the fetch pointer; a write in the start cycle lands
    // before the first fetch one edge later.
    always_ff @(posedge clk) begin
        if (bus.ld_en && (state_q != S_RUN)) begin
            store_q[bus.ld_addr] <= bus.ld_data;
        end
    end

    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    fpc_d   = '0;
                end
            end
            S_RUN: begin
                if (bus.br_en) begin
                    // Branch beats everything, including a presented halt;
                    // the presented instruction is dropped (one bubble).
                    valid_d = 1'b0;
                    fpc_d   = bus.br_target;
                end else if (halt_presented) begin
                    if (bus.ready) begin
                        valid_d = 1'b0;
                        state_d = S_HALTED;
                    end
                end else if (!valid_q || bus.ready) begin
                    instr_d = store_q[fpc_q];
                    pc_d    = fpc_q;
                    valid_d = 1'b1;
                    fpc_d   = fpc_q + 1'b1;   // DEPTH is a power of two: wraps
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d   = (state_d == S_RUN);
        halted_d = (state_d == S_HALTED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            fpc_q    <= '0;
            pc_q     <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            fpc_q    <= fpc_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
        end
    end

    assign bus.pc     = pc_q;
    assign bus.instr  = instr_q;
    assign bus.op     = op;
    assign bus.valid  = valid_q;
    assign bus.busy   = busy_q;
    assign bus.halted = halted_q;
endmodule

// File: tb/tb_prg_fetch.sv
module tb_prg_fetch;
    localparam int INSTR_W = 16;
    localparam int DEPTH   = 8;
    localparam int OP_W    = 4;
    localparam int AW      = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    prg_fetch_if #(.INSTR_W(INSTR_W), .DEPTH(DEPTH), .OP_W(OP_W)) bus ();

    prg_fetch #(.INSTR_W(INSTR_W), .DEPTH(DEPTH), .OP_W(OP_W), .HALT_OP(4'hF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // What the store should hold, from the loader's point of view.
    logic [INSTR_W-1:0] mstore [DEPTH];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ld_en = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
        bus.start = 1'b0; bus.br_en = 1'b0; bus.br_target = '0; bus.ready = 1'b0;
    endtask

    task automatic ld(input logic [AW-1:0] a, input logic [INSTR_W-1:0] d);
        bus.ld_en = 1'b1; bus.ld_addr = a; bus.ld_data = d;
        cyc();
        bus.ld_en = 1'b0;
        mstore[a] = d;
    endtask

    // 1000,2000,...,7000,F000
    task automatic load_halt_prog();
        for (int k = 0; k < 7; k++) ld(3'(k), 16'((k + 1) << 12));
        ld(3'd7, 16'hF000);
    endtask

    task automatic start_run();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    // Asynchronous pulse placed between clock edges.
    task automatic hard_reset();
        #2 rst = 1'b0;
        idle_inputs();
        #2 rst = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        #12;
        total++;
        if ({bus.pc, bus.instr, bus.op, bus.valid, bus.busy, bus.halted} !== '0) begin
            bad++;
            $display("FAIL reset_state pc=%h instr=%h op=%h v=%b busy=%b halted=%b, want all 0",
                     bus.pc, bus.instr, bus.op, bus.valid, bus.busy, bus.halted);
        end
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_reset_midrun();
        load_halt_prog();
        bus.ready = 1'b1;
        start_run();
        cyc(); cyc(); cyc();
        #3 rst = 1'b0;
        #1;
        total++;
        if ({bus.pc, bus.instr, bus.op, bus.valid, bus.busy, bus.halted} !== '0) begin
            bad++;
            $display("FAIL midrun_reset pc=%h instr=%h op=%h v=%b busy=%b halted=%b, want all 0",
                     bus.pc, bus.instr, bus.op, bus.valid, bus.busy, bus.halted);
        end
        #1 rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cyc();
            total++;
            if ({bus.valid, bus.busy, bus.halted} !== 3'b000) begin
                bad++;
                $display("FAIL midrun_stays_idle cyc=%0d v/busy/halted=%b want 000", c,
                         {bus.valid, bus.busy, bus.halted});
            end
        end
        bus.ready = 1'b0;
    endtask

    task automatic test_program();
        load_halt_prog();
        bus.ready = 1'b1;
        start_run();
        total++;
        if ({bus.busy, bus.valid} !== 2'b10) begin
            bad++;
            $display("FAIL start_latency busy=%b valid=%b want busy=1 valid=0", bus.busy, bus.valid);
        end
        for (int k = 0; k < 8; k++) begin
            cyc();
            total++;
            if (bus.valid !== 1'b1 || bus.pc !== 3'(k) || bus.op !== ((k < 7) ? 4'(k + 1) : 4'hF)
                || bus.instr !== ((k < 7) ? 16'((k + 1) << 12) : 16'hF000)) begin
                bad++;
                $display("FAIL program_seq k=%0d got v=%b pc=%0d op=%h instr=%h", k,
                         bus.valid, bus.pc, bus.op, bus.instr);
            end
        end
        cyc();
        total++;
        if ({bus.halted, bus.valid, bus.busy} !== 3'b100) begin
            bad++;
            $display("FAIL halt_entry halted/valid/busy=%b want 100", {bus.halted, bus.valid, bus.busy});
        end
        bus.ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bus.ready = 1'b1;
        start_run();          // restart from HALTED
        cyc(); cyc(); cyc();  // pc 0,1,2
        total++;
        if (bus.valid !== 1'b1 || bus.pc !== 3'd2) begin
            bad++;
            $display("FAIL bp_reach_pc2 got v=%b pc=%0d want v=1 pc=2", bus.valid, bus.pc);
        end
        bus.ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            total++;
            if (bus.valid !== 1'b1 || bus.pc !== 3'd2 || bus.instr !== 16'h3000) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d got v=%b pc=%0d instr=%h want 1/2/3000", c,
                         bus.valid, bus.pc, bus.instr);
            end
        end
        bus.ready = 1'b1;
        for (int k = 3; k < 8; k++) begin
            cyc();
            total++;
            if (bus.valid !== 1'b1 || bus.pc !== 3'(k) || bus.instr !== mstore[k]) begin
                bad++;
                $display("FAIL bp_resume k=%0d got v=%b pc=%0d instr=%h", k, bus.valid, bus.pc, bus.instr);
            end
        end
        cyc();
        total++;
        if (bus.halted !== 1'b1) begin
            bad++;
            $display("FAIL bp_halt halted=%b want 1", bus.halted);
        end
        bus.ready = 1'b0;
    endtask

    task automatic test_wrap();
        hard_reset();
        for (int k = 0; k < DEPTH; k++) ld(3'(k), 16'h1000 | 16'(k));
        bus.ready = 1'b1;
        start_run();
        for (int k = 0; k < 12; k++) begin
            cyc();
            total++;
            if (bus.valid !== 1'b1 || bus.pc !== 3'(k % DEPTH) || bus.instr !== (16'h1000 | 16'(k % DEPTH))) begin
                bad++;
                $display("FAIL wrap k=%0d got v=%b pc=%0d instr=%h", k, bus.valid, bus.pc, bus.instr);
            end
        end
        hard_reset();
    endtask

    task automatic test_branch();
        load_halt_prog();
        bus.ready = 1'b1;
        start_run();
        cyc(); cyc();
        total++;
        if (bus.valid !== 1'b1 || bus.pc !== 3'd1) begin
            bad++;
            $display("FAIL br_setup got v=%b pc=%0d want pc=1", bus.valid, bus.pc);
        end
        bus.br_en = 1'b1; bus.br_target = 3'd5;
        cyc();
        bus.br_en = 1'b0;
        total++;
        if (bus.valid !== 1'b0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL br_bubble got v=%b busy=%b want v=0 busy=1", bus.valid, bus.busy);
        end
        for (int k = 5; k < 8; k++) begin
            cyc();
            total++;
            if (bus.valid !== 1'b1 || bus.pc !== 3'(k) || bus.instr !== mstore[k]) begin
                bad++;
                $display("FAIL br_target_seq k=%0d got v=%b pc=%0d instr=%h", k, bus.valid, bus.pc, bus.instr);
            end
        end
        cyc();
        total++;
        if (bus.halted !== 1'b1) begin
            bad++;
            $display("FAIL br_then_halt halted=%b want 1", bus.halted);
        end
        bus.ready = 1'b0;
    endtask

    task automatic test_load_in_run();
        bus.ready = 1'b1;
        start_run();
        bus.ld_en = 1'b1; bus.ld_addr = 3'd3; bus.ld_data = 16'hAAAA;   // must be ignored
        for (int k = 0; k < 8; k++) begin
            cyc();
            total++;
            if (bus.valid !== 1'b1 || bus.pc !== 3'(k) || bus.instr !== mstore[k]) begin
                bad++;
                $display("FAIL run_load_ignored k=%0d got pc=%0d instr=%h want %h", k, bus.pc,
                         bus.instr, mstore[k]);
            end
        end
        bus.ld_en = 1'b0;
        cyc();
        total++;
        if (bus.halted !== 1'b1) begin
            bad++;
            $display("FAIL run_load_halt halted=%b want 1", bus.halted);
        end
        ld(3'd0, 16'h2ABC);
        // Write in the same cycle as start must be seen by the fetch.
        bus.ld_en = 1'b1; bus.ld_addr = 3'd1; bus.ld_data = 16'h5123;
        start_run();
        bus.ld_en = 1'b0;
        mstore[1] = 16'h5123;
        cyc();
        total++;
        if (bus.valid !== 1'b1 || bus.pc !== 3'd0 || bus.instr !== 16'h2ABC || bus.op !== 4'h2) begin
            bad++;
            $display("FAIL reload_first got v=%b pc=%0d instr=%h op=%h want 2ABC op 2", bus.valid,
                     bus.pc, bus.instr, bus.op);
        end
        cyc();
        total++;
        if (bus.valid !== 1'b1 || bus.pc !== 3'd1 || bus.instr !== 16'h5123) begin
            bad++;
            $display("FAIL load_with_start got pc=%0d instr=%h want pc=1 5123", bus.pc, bus.instr);
        end
        hard_reset();
    endtask

    // Transaction-level scoreboard: the presented address follows the last
    // accepted one (+1), a branch target, or 0 after start; every presented
    // instruction must equal the loader's image of the store.
    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            logic [AW-1:0]      exp_addr;
            logic               v0;
            logic [AW-1:0]      p0;
            logic [INSTR_W-1:0] i0;
            logic               rdy, br;
            logic [AW-1:0]      tgt;
            bit                 done;
            for (int a = 0; a < DEPTH; a++)
                ld(3'(a), {4'($urandom_range(0, 14)), 12'($urandom)});
            if ($urandom_range(0, 1) == 1) ld(3'($urandom_range(1, DEPTH - 1)), 16'hF000 | 16'($urandom_range(0, 4095)));
            start_run();
            exp_addr = '0;
            done = 0;
            for (int c = 0; c < 60 && !done; c++) begin
                rdy = ($urandom_range(0, 9) < 7);
                br  = ($urandom_range(0, 9) == 0);
                tgt = 3'($urandom_range(0, DEPTH - 1));
                bus.ready = rdy; bus.br_en = br; bus.br_target = tgt;
                bus.ld_en = ($urandom_range(0, 3) == 0);
                bus.ld_addr = 3'($urandom_range(0, DEPTH - 1));
                bus.ld_data = 16'($urandom);
                v0 = bus.valid; p0 = bus.pc; i0 = bus.instr;
                cyc();
                total++;
                if (br) begin
                    exp_addr = tgt;
                    if (bus.valid !== 1'b0 || bus.busy !== 1'b1) begin
                        bad++;
                        $display("FAIL rnd_branch r=%0d c=%0d v=%b busy=%b", r, c, bus.valid, bus.busy);
                    end
                end else if (v0 && rdy && i0[15:12] == 4'hF) begin
                    done = 1;
                    if ({bus.halted, bus.busy, bus.valid} !== 3'b100 || bus.pc !== p0 || bus.instr !== i0) begin
                        bad++;
                        $display("FAIL rnd_halt r=%0d c=%0d h/b/v=%b pc=%0d instr=%h", r, c,
                                 {bus.halted, bus.busy, bus.valid}, bus.pc, bus.instr);
                    end
                end else if (v0 && !rdy) begin
                    if (bus.valid !== 1'b1 || bus.pc !== p0 || bus.instr !== i0) begin
                        bad++;
                        $display("FAIL rnd_hold r=%0d c=%0d v=%b pc=%0d instr=%h want pc=%0d instr=%h",
                                 r, c, bus.valid, bus.pc, bus.instr, p0, i0);
                    end
                end else begin
                    if (v0) exp_addr = p0 + 1'b1;
                    if (bus.valid !== 1'b1 || bus.pc !== exp_addr || bus.instr !== mstore[exp_addr]) begin
                        bad++;
                        $display("FAIL rnd_fetch r=%0d c=%0d v=%b pc=%0d instr=%h want pc=%0d instr=%h",
                                 r, c, bus.valid, bus.pc, bus.instr, exp_addr, mstore[exp_addr]);
                    end
                end
            end
            hard_reset();
        end
    endtask

    initial begin
        test_reset();
        test_reset_midrun();
        test_program();
        test_backpressure();
        test_wrap();
        test_branch();
        test_load_in_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/prg_fetch.md
# prg_fetch

Parametrised program-fetch unit: a writable DEPTH-entry instruction store, a wrapping program counter, and a registered instruction output stage with a valid/ready handshake toward the control unit. Programs are loaded through a write port rather than read from a file. Run, branch redirect and halt are handled by a three-state controller. The block sits between the program loader/testbench and the control unit, which consumes `pc`, `instr` and `op`.

## Interface
- `INSTR_W`, 16: instruction width in bits.
- `DEPTH`, 8: instruction-store entries; power of two, ≥2. AW = $clog2(DEPTH).
- `OP_W`, 4: opcode width; opcode = instr[INSTR_W-1 -: OP_W].
- `HALT_OP`, 4'hF: opcode value that stops fetching.
- `clk`  in  1  single clock; everything is updated on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ld_en`  in  1  write `ld_data` to store[`ld_addr`].
- `ld_addr`  in  AW  store write address.
- `ld_data`  in  INSTR_W  store write data.
- `start`  in  1  begin execution from address 0.
- `br_en`  in  1  redirect fetch to `br_target`.
- `br_target`  in  AW  branch destination address.
- `ready`  in  1  consumer accepts the current instruction.
- `pc`  out  AW  address of the instruction currently presented.
- `instr`  out  INSTR_W  presented instruction (registered).
- `op`  out  OP_W  opcode field of `instr`; combinational from the `instr` register.
- `valid`  out  1  `instr`/`pc`/`op` are meaningful.
- `busy`  out  1  state == RUN.
- `halted`  out  1  state == HALTED.

## Operation
- Internal state: fetch pointer `fpc` (AW bits), controller state ∈ {IDLE, RUN, HALTED}.
- Store: DEPTH×INSTR_W array.
  - Never cleared by reset.
  - Writes are accepted only in IDLE or HALTED; `ld_en` in RUN is ignored.
- IDLE:
  - `start` → RUN and `fpc` ← 0.
  - `br_en` and `ready` are ignored.
- RUN, in priority order:
  1. `br_en`: `valid` ← 0 (the presented instruction is discarded even if `ready`=1) and `fpc` ← `br_target`.
  2. Output holds a HALT_OP instruction (`valid`=1 and `op`==HALT_OP):
     - No further fetch.
     - On `ready`: `valid` ← 0 and state → HALTED.
  3. `!valid || ready`: load the output stage: `instr` ← store[`fpc`], `pc` ← `fpc`, `valid` ← 1, `fpc` ← `fpc`+1 mod DEPTH.
  4. Otherwise (`valid`=1, `ready`=0): hold all outputs and `fpc`.
- HALTED:
  - `pc`/`instr` hold their last values; `valid`=0.
  - `start` → RUN with `fpc` ← 0 (restart).
  - Loading is allowed.
- `start` in RUN is ignored.
- Wrap: `fpc`=DEPTH-1 advances to 0; there is no end-of-program stop other than HALT_OP.
- A write to store[k] in the same cycle `start` is sampled is visible to the first fetch.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State IDLE, `fpc`=0, `pc`=0, `instr`=0, `op`=0, `valid`=0, `busy`=0, `halted`=0.
  - Reset asserted mid-RUN aborts immediately; the next run needs `start`.
- Start latency: `start` sampled at edge N → `busy`=1 after N; `valid`=1 with `pc`=0 after N+1.
- Throughput: one instruction per cycle while `ready`=1.
- Back-pressure: `ready`=0 holds `instr`/`pc`/`valid` stable.
- Branch penalty: `br_en` at edge N → `valid`=0 after N; `instr`=store[`br_target`] valid after N+1. Exactly one bubble.
- Halt: a HALT_OP instruction accepted at edge N → `valid`=0, `busy`=0, `halted`=1 after N.
- `br_en` while a HALT_OP instruction is presented: the branch wins and execution continues.

## Test plan
- Reset mid-RUN: assert `rst`=0 asynchronously between edges → all outputs read their reset values immediately and the block is IDLE.
- Load store[0..7] = 16'h1000..16'h7000, 16'hF000; `start`; `ready`=1 → `pc` 0..7 on consecutive cycles, `op`=1..7 then F; one cycle after F is accepted, `halted`=1 and `valid`=0.
- Same program; `ready`=0 for 3 cycles while `pc`=2 → `instr`=16'h3000 held for 3 cycles; the sequence then resumes at `pc`=3 with no skipped or duplicated entry.
- Store with no HALT_OP (all 16'h1xxx), DEPTH=8 → after `pc`=7 the next presented is `pc`=0 (wrap).
- `br_en`=1, `br_target`=5 while `pc`=1 is presented with `ready`=1 → next cycle `valid`=0, following cycle `pc`=5 and `instr`=store[5]; the instruction at `pc`=1 is never accepted.
- `ld_en` attempted during RUN → store unchanged. After HALTED: reload store[0]=16'h2ABC, then `start` → first `instr`=16'h2ABC, `op`=2.
